debounce_pulse: RTL and testbench

Input-conditioning stage for a raw asynchronous button or switch. It synchronizes the input, qualifies it as stable for a programmable number of clocks, and produces a clean registered level plus single-cycle rise/fall pulses. It sits directly upstream of the lab's single-bit delay-chain modules and drives their data input with `level`. A wrapping press counter is provided for board display and for bench checking.

---
 rtl/debounce_pulse.sv | 134 +++++++++++++
 tb/tb_debounce_pulse.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Button/switch conditioner: synchronizer, stability qualifier FSM, registered
// level with one-cycle rise/fall pulses and a wrapping press counter.
module debounce_pulse #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int PCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_in,
  output logic              level,
  output logic              rise,
  output logic              fall,
  output logic              busy,
  output logic [PCNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              level_reg, level_next;
  logic              rise_reg, rise_next;
  logic              fall_reg, fall_next;
  logic              busy_reg, busy_next;
  logic [PCNT_W-1:0] press_reg, press_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Only the last synchronizer stage is ever observed by the qualifier.
  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      press_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      busy_reg  <= busy_next;
      press_reg <= press_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    press_next = press_reg;

    case (state_reg)
      S_LOW: begin
        if (s) begin
          state_next = S_WAIT_HI;
          cnt_next   = CNT_W'(1);
        end
      end
      S_WAIT_HI: begin
        if (!s) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = S_HIGH;
          level_next = 1'b1;
          rise_next  = 1'b1;
          press_next = press_reg + PCNT_W'(1);
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_next = S_WAIT_LO;
          cnt_next   = CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (s) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = S_LOW;
          level_next = 1'b0;
          fall_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
      end
    endcase

    // Registered so busy reflects the state being entered, with no extra lag.
    busy_next = (state_next == S_WAIT_HI) || (state_next == S_WAIT_LO);
  end

  assign level     = level_reg;
  assign rise      = rise_reg;
  assign fall      = fall_reg;
  assign busy      = busy_reg;
  assign press_cnt = press_reg;

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: reset/press table, hand-written corner sequences,
// and a randomized run compared cycle by cycle against a run-length model.
module tb_debounce_pulse;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int PCNT_W = 8;

  logic              clk;
  logic              rst;
  logic              btn_in;
  logic              level;
  logic              rise;
  logic              fall;
  logic              busy;
  logic [PCNT_W-1:0] press_cnt;

  int n_vec = 0;
  int n_err = 0;

  debounce_pulse #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (16),
    .PCNT_W       (PCNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy),
    .press_cnt(press_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the value seen by the qualifier is btn_in delayed SYNC edges;
  // level follows the current run of identical samples once it reaches STABLE.
  logic              m_hist[$];
  logic              m_run_val;
  int                m_run_len;
  logic              m_level, m_rise, m_fall, m_busy;
  logic [PCNT_W-1:0] m_press;

  task automatic model_reset();
    m_hist.delete();
    m_run_val = 1'b0;
    m_run_len = 0;
    m_level   = 1'b0;
    m_rise    = 1'b0;
    m_fall    = 1'b0;
    m_busy    = 1'b0;
    m_press   = '0;
  endtask

  task automatic model_edge(input logic r, input logic b);
    logic samp;
    if (r) begin
      model_reset();
      return;
    end
    samp = (m_hist.size() >= SYNC) ? m_hist[m_hist.size() - SYNC] : 1'b0;
    m_hist.push_back(b);
    if (m_hist.size() > SYNC) void'(m_hist.pop_front());
    if (samp == m_run_val) m_run_len++;
    else begin
      m_run_val = samp;
      m_run_len = 1;
    end
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (m_run_val != m_level && m_run_len >= STABLE) begin
      m_level = m_run_val;
      if (m_level) begin
        m_rise  = 1'b1;
        m_press = m_press + 1'b1;
      end else begin
        m_fall = 1'b1;
      end
    end
    m_busy = (m_run_val != m_level);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input bit use_model);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    #1;
    model_edge(r, b);
    if (use_model) begin
      check("level", 32'(level), 32'(m_level));
      check("rise", 32'(rise), 32'(m_rise));
      check("fall", 32'(fall), 32'(m_fall));
      check("busy", 32'(busy), 32'(m_busy));
      check("press_cnt", 32'(press_cnt), 32'(m_press));
      if (rise && fall) check("rise_fall_excl", 32'(1), 32'(0));
    end
  endtask

  typedef struct {
    logic              r;
    logic              b;
    logic              lvl;
    logic              ri;
    logic              fa;
    logic              bs;
    logic [PCNT_W-1:0] pc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int   rise_seen, fall_seen, busy_seen, at;
    logic b;

    rst    = 1'b1;
    btn_in = 1'b1;
    model_reset();

    // Button held high across a 3-cycle reset, then qualified from scratch.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[8]  = '{0, 1, 1, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 1, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 1, 0, 0, 0, 1};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].b, 0);
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      check($sformatf("tbl%0d_rise", i), 32'(rise), 32'(tbl[i].ri));
      check($sformatf("tbl%0d_fall", i), 32'(fall), 32'(tbl[i].fa));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bs));
      check($sformatf("tbl%0d_press", i), 32'(press_cnt), 32'(tbl[i].pc));
    end

    // Glitch: three high samples are one short of qualifying.
    step(1, 0, 1); step(1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    rise_seen = 0; busy_seen = 0;
    for (int i = 0; i < 3; i++) begin step(0, 1, 1); busy_seen += busy; rise_seen += rise; end
    for (int i = 0; i < 8; i++) begin step(0, 0, 1); busy_seen += busy; rise_seen += rise; end
    check("glitch_busy_seen", 32'(busy_seen > 0), 32'(1));
    check("glitch_no_rise", 32'(rise_seen), 32'(0));
    check("glitch_level", 32'(level), 32'(0));
    check("glitch_press", 32'(press_cnt), 32'(0));

    // Clean press, 2-cycle low glitch while high, then real release.
    for (int i = 0; i < 8; i++) step(0, 1, 1);
    check("press_level", 32'(level), 32'(1));
    check("press_cnt1", 32'(press_cnt), 32'(1));
    fall_seen = 0;
    for (int i = 0; i < 2; i++) begin step(0, 0, 1); fall_seen += fall; end
    for (int i = 0; i < 8; i++) begin step(0, 1, 1); fall_seen += fall; end
    check("lowglitch_no_fall", 32'(fall_seen), 32'(0));
    check("lowglitch_level", 32'(level), 32'(1));
    fall_seen = 0; at = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1);
      if (fall) begin fall_seen++; at = i + 1; end
    end
    check("release_fall_edge", 32'(at), 32'(SYNC + STABLE));
    check("release_fall_count", 32'(fall_seen), 32'(1));
    check("release_level", 32'(level), 32'(0));
    check("release_press", 32'(press_cnt), 32'(1));

    // Reset while qualifying a press: abandoned, then re-qualified.
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1);
    check("midq_busy", 32'(busy), 32'(1));
    step(1, 1, 1);
    check("midq_rst_rise", 32'(rise), 32'(0));
    check("midq_rst_press", 32'(press_cnt), 32'(0));
    check("midq_rst_busy", 32'(busy), 32'(0));
    at = 0; rise_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1);
      if (rise) begin rise_seen++; if (at == 0) at = i + 1; end
    end
    check("midq_rise_edge", 32'(at), 32'(SYNC + STABLE));
    check("midq_rise_count", 32'(rise_seen), 32'(1));
    check("midq_press", 32'(press_cnt), 32'(1));

    // Wrap: 256 clean presses from a fresh reset.
    step(1, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    rise_seen = 0;
    for (int p = 1; p <= 256; p++) begin
      for (int i = 0; i < 7; i++) begin step(0, 1, 1); rise_seen += rise; end
      if (p == 255) check("wrap_255", 32'(press_cnt), 32'(255));
      if (p == 256) check("wrap_0", 32'(press_cnt), 32'(0));
      for (int i = 0; i < 7; i++) begin step(0, 0, 1); rise_seen += rise; end
    end
    check("wrap_rise_count", 32'(rise_seen), 32'(256));

    // Randomized bouncing with occasional resets.
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(($urandom_range(0, 299) == 0), b, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
